// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target responder: FSM encoding and bus-level ACK values.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR        = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD        = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // True when the received address byte (addr[7:1], R/W in bit 0) selects this target.
  function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] own_addr);
    return (addr_byte[7:1] == own_addr);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Pad synchronisers for SCL/SDA plus one history stage; derives bus edge and START/STOP events.
module i2c_line_sync (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_meta_r, scl_sync_r, scl_hist_r;
  logic sda_meta_r, sda_sync_r, sda_hist_r;

  // Idle bus is high, so reset to 1 to avoid phantom edges when reset is released.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_hist_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_meta_r <= scl_in;
      scl_sync_r <= scl_meta_r;
      scl_hist_r <= scl_sync_r;
      sda_meta_r <= sda_in;
      sda_sync_r <= sda_meta_r;
      sda_hist_r <= sda_sync_r;
    end
  end

  assign scl_rise  = scl_sync_r & ~scl_hist_r;
  assign scl_fall  = ~scl_sync_r & scl_hist_r;
  assign start_det = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
  assign stop_det  = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;
  assign sda_s     = sda_sync_r;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, ACK generation, write-byte delivery and read-byte serving.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_s;

  i2c_line_sync u_sync (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_det_s),
    .stop_det  (stop_det_s),
    .sda_s     (sda_s)
  );

  i2c_state_e state_r, state_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] shreg_r, shreg_s;
  logic       rw_r, rw_s;
  // byte_full marks that the 8th rising edge of a byte has been seen; ack_seen marks a master ACK.
  logic       byte_full_r, byte_full_s;
  logic       ack_seen_r, ack_seen_s;
  logic       sda_oe_r, sda_oe_s;
  logic [7:0] rx_data_r, rx_data_s;
  logic       rx_valid_r, rx_valid_s;
  logic       tx_req_r, tx_req_s;
  logic       busy_r, busy_s;

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shreg_r     <= 8'h00;
      rw_r        <= 1'b0;
      byte_full_r <= 1'b0;
      ack_seen_r  <= 1'b0;
      sda_oe_r    <= 1'b0;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      tx_req_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      shreg_r     <= shreg_s;
      rw_r        <= rw_s;
      byte_full_r <= byte_full_s;
      ack_seen_r  <= ack_seen_s;
      sda_oe_r    <= sda_oe_s;
      rx_data_r   <= rx_data_s;
      rx_valid_r  <= rx_valid_s;
      tx_req_r    <= tx_req_s;
      busy_r      <= busy_s;
    end
  end

  // Next-state logic; bus conditions pre-empt any bit processing in the same cycle.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shreg_s     = shreg_r;
    rw_s        = rw_r;
    byte_full_s = byte_full_r;
    ack_seen_s  = ack_seen_r;
    sda_oe_s    = sda_oe_r;
    rx_data_s   = rx_data_r;
    rx_valid_s  = 1'b0;
    tx_req_s    = 1'b0;
    busy_s      = busy_r;

    if (start_det_s) begin
      state_s     = ST_ADDR;
      bit_cnt_s   = 3'd0;
      byte_full_s = 1'b0;
      ack_seen_s  = 1'b0;
      sda_oe_s    = 1'b0;
    end else if (stop_det_s) begin
      state_s     = ST_IDLE;
      byte_full_s = 1'b0;
      ack_seen_s  = 1'b0;
      sda_oe_s    = 1'b0;
      busy_s      = 1'b0;
    end else begin
      case (state_r)
        ST_ADDR: begin
          if (scl_rise_s) begin
            shreg_s     = {shreg_r[6:0], sda_s};
            bit_cnt_s   = bit_cnt_r + 3'd1;
            byte_full_s = (bit_cnt_r == 3'd7);
          end else if (scl_fall_s && byte_full_r) begin
            byte_full_s = 1'b0;
            if (addr_hit(shreg_r, SLAVE_ADDR)) begin
              sda_oe_s = 1'b1;
              busy_s   = 1'b1;
              rw_s     = shreg_r[0];
              state_s  = ST_ADDR_ACK;
            end else begin
              busy_s  = 1'b0;
              state_s = ST_WAIT_STOP;
            end
          end else begin
            state_s = state_r;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_rise_s) begin
            tx_req_s = rw_r;
          end else if (scl_fall_s) begin
            bit_cnt_s = 3'd0;
            if (rw_r) begin
              shreg_s  = tx_data;
              sda_oe_s = ~tx_data[7];
              state_s  = ST_RD;
            end else begin
              sda_oe_s = 1'b0;
              state_s  = ST_WR;
            end
          end else begin
            state_s = state_r;
          end
        end
        ST_WR: begin
          if (scl_rise_s) begin
            shreg_s     = {shreg_r[6:0], sda_s};
            bit_cnt_s   = bit_cnt_r + 3'd1;
            byte_full_s = (bit_cnt_r == 3'd7);
            if (bit_cnt_r == 3'd7) begin
              rx_data_s  = {shreg_r[6:0], sda_s};
              rx_valid_s = 1'b1;
            end else begin
              rx_valid_s = 1'b0;
            end
          end else if (scl_fall_s && byte_full_r) begin
            byte_full_s = 1'b0;
            sda_oe_s    = 1'b1;
            state_s     = ST_WR_ACK;
          end else begin
            state_s = state_r;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall_s) begin
            sda_oe_s  = 1'b0;
            bit_cnt_s = 3'd0;
            state_s   = ST_WR;
          end else begin
            state_s = state_r;
          end
        end
        ST_RD: begin
          if (scl_rise_s) begin
            bit_cnt_s   = bit_cnt_r + 3'd1;
            byte_full_s = (bit_cnt_r == 3'd7);
          end else if (scl_fall_s) begin
            if (byte_full_r) begin
              byte_full_s = 1'b0;
              ack_seen_s  = 1'b0;
              sda_oe_s    = 1'b0;
              state_s     = ST_RD_ACK;
            end else begin
              shreg_s  = {shreg_r[6:0], 1'b0};
              sda_oe_s = ~shreg_r[6];
            end
          end else begin
            state_s = state_r;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise_s) begin
            if (sda_s == I2C_ACK) begin
              tx_req_s   = 1'b1;
              ack_seen_s = 1'b1;
            end else begin
              sda_oe_s = 1'b0;
              state_s  = ST_WAIT_STOP;
            end
          end else if (scl_fall_s && ack_seen_r) begin
            ack_seen_s = 1'b0;
            bit_cnt_s  = 3'd0;
            shreg_s    = tx_data;
            sda_oe_s   = ~tx_data[7];
            state_s    = ST_RD;
          end else begin
            state_s = state_r;
          end
        end
        ST_IDLE, ST_WAIT_STOP: state_s = state_r;
        default: begin
          state_s  = ST_IDLE;
          sda_oe_s = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign tx_req   = tx_req_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed + randomised bench: bus-level I2C master with open-drain SDA and a byte-queue client model.
module tb_i2c_slave_responder;
  import i2c_pkg::*;

  localparam logic [6:0] OWN_ADDR = 7'h42;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic       sda_line;

  int vectors = 0;
  int miscompares = 0;
  int tx_req_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(OWN_ADDR)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Client model: collects written bytes, answers each tx_req with the next queued byte.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_req) begin
        tx_req_cnt++;
        if (tx_q.size() > 0) tx_data = tx_q.pop_front();
        else tx_data = 8'hFF;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Quarter SCL period = 5 sys_clk cycles (SCL = sys_clk / 20).
  task automatic qwait();
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; qwait(); qwait(); scl = 1'b0;
  endtask

  task automatic bus_rstart();
    qwait(); sda_m = 1'b1; qwait(); scl = 1'b1; qwait(); qwait();
    sda_m = 1'b0; qwait(); qwait(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    qwait(); sda_m = 1'b0; qwait(); scl = 1'b1; qwait(); qwait();
    sda_m = 1'b1; qwait(); qwait();
  endtask

  task automatic wbit(input logic b);
    qwait(); sda_m = b; qwait(); scl = 1'b1; qwait(); qwait(); scl = 1'b0;
  endtask

  task automatic rbit(output logic b);
    qwait(); sda_m = 1'b1; qwait(); scl = 1'b1; qwait(); b = sda_line; qwait(); scl = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack_v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(ack_v);
  endtask

  // Reference rule: the target acknowledges iff the 7-bit address matches.
  function automatic logic exp_ack(input logic [7:0] addr_byte);
    return (addr_byte[7:1] == OWN_ADDR) ? I2C_ACK : I2C_NACK;
  endfunction

  // Complete write transfer; matched writes must arrive unchanged, unmatched ones must vanish.
  task automatic write_xfer(input string tag, input logic [7:0] addr, input logic [7:0] data[$]);
    logic a;
    logic hit;
    hit = (exp_ack(addr) == I2C_ACK);
    rx_q.delete();
    bus_start();
    wbyte(addr, a);
    chk({tag, "_addr_ack"}, {31'd0, a}, {31'd0, exp_ack(addr)});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, hit});
    foreach (data[i]) begin
      wbyte(data[i], a);
      chk({tag, "_data_ack"}, {31'd0, a}, {31'd0, hit ? I2C_ACK : I2C_NACK});
    end
    bus_stop();
    chk({tag, "_rx_count"}, rx_q.size(), hit ? data.size() : 0);
    if (hit) begin
      for (int i = 0; i < data.size(); i++) begin
        chk({tag, "_rx_byte"}, {24'd0, (i < rx_q.size()) ? rx_q[i] : 8'hxx}, {24'd0, data[i]});
      end
    end
    chk({tag, "_busy_after_stop"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sda_oe_after_stop"}, {31'd0, sda_oe}, 32'd0);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    logic [7:0] exp_b;
    logic [7:0] wq[$];

    // Reset state
    repeat (4) @(negedge sys_clk);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge sys_clk);

    // 1: write two bytes to our address
    wq = '{8'hA5, 8'h3C};
    write_xfer("wr1", 8'h84, wq);

    // 1b: randomised payload
    wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    write_xfer("wr_rand", 8'h84, wq);

    // 2: foreign address
    wq = '{8'hFF};
    write_xfer("wr_other", 8'h90, wq);

    // 3: read two bytes, ACK then NACK
    tx_q = '{8'h5A, 8'hC3};
    tx_req_cnt = 0;
    bus_start();
    wbyte(8'h85, a);
    chk("rd_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    rbyte(d, I2C_ACK);
    chk("rd_byte0", {24'd0, d}, 32'h5A);
    rbyte(d, I2C_NACK);
    chk("rd_byte1", {24'd0, d}, 32'hC3);
    qwait(); qwait();
    chk("rd_release_oe", {31'd0, sda_oe}, 32'd0);
    chk("rd_release_line", {31'd0, sda_line}, 32'd1);
    chk("rd_tx_req_cnt", tx_req_cnt, 32'd2);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    bus_stop();
    chk("rd_busy_after_stop", {31'd0, busy}, 32'd0);

    // 4: write, repeated START, read
    exp_b = 8'($urandom);
    tx_q = '{exp_b};
    tx_req_cnt = 0;
    rx_q.delete();
    bus_start();
    wbyte(8'h84, a);
    chk("rs_wr_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    wbyte(8'h11, a);
    chk("rs_wr_data_ack", {31'd0, a}, {31'd0, I2C_ACK});
    bus_rstart();
    wbyte(8'h85, a);
    chk("rs_rd_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    chk("rs_tx_req_cnt", tx_req_cnt, 32'd1);
    rbyte(d, I2C_NACK);
    chk("rs_rd_byte", {24'd0, d}, {24'd0, exp_b});
    bus_stop();
    chk("rs_rx_count", rx_q.size(), 32'd1);
    chk("rs_rx_byte", {24'd0, (rx_q.size() > 0) ? rx_q[0] : 8'hxx}, 32'h11);

    // 5: reset while target drives a 0 bit
    tx_q = '{8'($urandom_range(0, 127))};
    bus_start();
    wbyte(8'h85, a);
    chk("rst_mid_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    qwait(); sda_m = 1'b1; qwait(); scl = 1'b1; qwait();
    chk("rst_mid_driving", {31'd0, sda_oe}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    wq = '{8'h22};
    write_xfer("post_rst", 8'h84, wq);

    // 6: STOP in the middle of a data byte
    rx_q.delete();
    bus_start();
    wbyte(8'h84, a);
    chk("mid_stop_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    for (int i = 0; i < 4; i++) wbit(1'($urandom));
    bus_stop();
    chk("mid_stop_rx_count", rx_q.size(), 32'd0);
    chk("mid_stop_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("mid_stop_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
